// File: rtl/pio_out_blink.sv
`timescale 1ns/1ps
// pio_out_blink: Avalon-MM output port with atomic bit set/clear and a per-bit
// blink engine gated by a shared, programmable prescaler phase.
module pio_out_blink #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned DIV_WIDTH    = 24,
   parameter int unsigned RESET_VALUE  = 0,
   parameter int unsigned RESET_PERIOD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic [2:0] {
      ADDR_DATA     = 3'd0,
      ADDR_MASK     = 3'd1,
      ADDR_PERIOD   = 3'd2,
      ADDR_STATUS   = 3'd3,
      ADDR_OUTSET   = 3'd4,
      ADDR_OUTCLEAR = 3'd5
   } addr_e;

   localparam logic [WIDTH-1:0]     DATA_INIT   = WIDTH'(RESET_VALUE);
   localparam logic [DIV_WIDTH-1:0] PERIOD_INIT = DIV_WIDTH'(RESET_PERIOD);

   logic [WIDTH-1:0]     data;
   logic [WIDTH-1:0]     blink_mask;
   logic [DIV_WIDTH-1:0] period;
   logic [DIV_WIDTH-1:0] cnt;
   logic                 phase;
   logic [31:0]          rd_mux;

   logic                 wr;
   logic                 period_wr;
   logic [WIDTH-1:0]     wd_bits;

   // Upper writedata bits beyond WIDTH/DIV_WIDTH are deliberately dropped.
   logic                 unused_wd;

   assign wr        = chipselect & ~write_n;
   assign period_wr = wr && (address == ADDR_PERIOD);
   assign wd_bits   = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= DATA_INIT;
         blink_mask <= '0;
         period     <= PERIOD_INIT;
      end else if (wr) begin
         unique case (address)
            ADDR_DATA:     data       <= wd_bits;
            ADDR_MASK:     blink_mask <= wd_bits;
            ADDR_PERIOD:   period     <= writedata[DIV_WIDTH-1:0];
            ADDR_OUTSET:   data       <= data | wd_bits;
            ADDR_OUTCLEAR: data       <= data & ~wd_bits;
            default:       ;
         endcase
      end
   end

   // A period write restarts the sequence and takes priority over a wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (period_wr) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == period) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   // NOTE: rd_mux gets a default before the case so no latch is inferred.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:   rd_mux[WIDTH-1:0]     = data;
         ADDR_MASK:   rd_mux[WIDTH-1:0]     = blink_mask;
         ADDR_PERIOD: rd_mux[DIV_WIDTH-1:0] = period;
         ADDR_STATUS: rd_mux[0]             = phase;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
         out_port <= DATA_INIT;
      end else begin
         readdata <= rd_mux;
         out_port <= data & (~blink_mask | {WIDTH{phase}});
      end
   end

endmodule

// File: tb/tb_pio_out_blink.sv
`timescale 1ns/1ps
// tb_pio_out_blink: scoreboard bench; expectations are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled on negedge.
module tb_pio_out_blink;

   localparam int WIDTH        = 4;
   localparam int DIV_WIDTH    = 24;
   localparam int RESET_VALUE  = 0;
   localparam int RESET_PERIOD = 7;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   pio_out_blink #(
      .WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH),
      .RESET_VALUE(RESET_VALUE), .RESET_PERIOD(RESET_PERIOD)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   // Bus tasks start and end on a falling edge.
   task automatic drive_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic drive_read(input logic [2:0] a);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      sb_q.push_back('{"rst_out", 32'(RESET_VALUE)});
      sb_q.push_back('{"rst_rd", 32'h0});
      e = sb_q.pop_front(); n_checks++;
      if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"rst_status", 32'h0});
      drive_read(3);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"rst_period", 32'(RESET_PERIOD)});
      drive_read(2);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
   endtask

   task automatic test_data();
      exp_t e;
      // One edge after the strobe the pin has not moved yet.
      sb_q.push_back('{"data_pin_lat1", 32'h0});
      drive_write(0, 32'hA);
      e = sb_q.pop_front(); n_checks++;
      if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;

      sb_q.push_back('{"data_rd", 32'h0000_000A});
      sb_q.push_back('{"data_pin_lat2", 32'hA});
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      e = sb_q.pop_front(); n_checks++;
      if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;

      sb_q.push_back('{"data_trunc", 32'h5});
      drive_write(0, 32'hFFFF_FFF5);
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      // A read at the same edge as a write returns the pre-write value.
      sb_q.push_back('{"rd_during_wr", 32'h5});
      drive_write(0, 32'h9);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"period_trunc", 32'h00FF_FFFF});
      drive_write(2, 32'hFFFF_FFFF);
      drive_read(2);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
   endtask

   task automatic test_set_clear();
      exp_t e;
      drive_write(0, 32'h1);
      sb_q.push_back('{"outset", 32'h7});
      drive_write(4, 32'h6);
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"outclear", 32'h4});
      drive_write(5, 32'h3);
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"b2b_rd", 32'h1});
      sb_q.push_back('{"b2b_pin", 32'h1});
      drive_write(4, 32'h1);
      drive_write(5, 32'h4);
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      e = sb_q.pop_front(); n_checks++;
      if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;

      sb_q.push_back('{"reserved_wr_ignored", 32'h1});
      drive_write(6, 32'hF);
      drive_write(7, 32'hF);
      drive_read(0);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      for (int a = 4; a < 8; a++) begin
         sb_q.push_back('{$sformatf("rd_addr%0d", a), 32'h0});
         drive_read(3'(a));
         e = sb_q.pop_front(); n_checks++;
         if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      end
   endtask

   task automatic test_blink();
      exp_t e;
      int   ph;
      drive_write(0, 32'hF);
      drive_write(1, 32'h3);
      sb_q.push_back('{"mask_rd", 32'h3});
      drive_read(1);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      // period = 3: phase holds for 4 cycles; pins lag phase by one edge.
      drive_write(2, 32'h3);
      address = 3;
      for (int k = 1; k <= 16; k++) begin
         ph = ((k - 1) / 4) % 2;
         sb_q.push_back('{$sformatf("blink3_pin_k%0d", k), (ph != 0) ? 32'hF : 32'hC});
         sb_q.push_back('{$sformatf("blink3_status_k%0d", k), 32'(ph)});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
         e = sb_q.pop_front(); n_checks++;
         if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      end

      drive_write(2, 32'h0);
      address = 3;
      for (int k = 1; k <= 6; k++) begin
         ph = (k - 1) % 2;
         sb_q.push_back('{$sformatf("blink0_pin_k%0d", k), (ph != 0) ? 32'hF : 32'hC});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      end
   endtask

   task automatic test_period_restart();
      exp_t e;
      int   ph;
      drive_write(2, 32'h9);
      idle(14);
      // phase = 1 and cnt = 5 going into the restarting write.
      sb_q.push_back('{"pre_restart_phase", 32'h1});
      drive_read(3);
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      drive_write(2, 32'h2);
      address = 3;
      for (int k = 1; k <= 7; k++) begin
         ph = (k >= 4 && k <= 6) ? 1 : 0;
         sb_q.push_back('{$sformatf("restart_status_k%0d", k), 32'(ph)});
         sb_q.push_back('{$sformatf("restart_pin_k%0d", k), (ph != 0) ? 32'hF : 32'hC});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
         e = sb_q.pop_front(); n_checks++;
         if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      end

      // Write lands on the wrap edge; the restart must win (phase stays 0).
      idle(1);
      drive_write(2, 32'h2);
      address = 3;
      for (int k = 1; k <= 4; k++) begin
         sb_q.push_back('{$sformatf("wrap_wr_status_k%0d", k), (k == 4) ? 32'h1 : 32'h0});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   ph;
      drive_write(0, 32'h3);
      idle(2);
      // Reset with a coincident outset that must be discarded.
      reset = 1'b1; address = 4; writedata = 32'hC; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      sb_q.push_back('{"mid_rst_pin", 32'(RESET_VALUE)});
      sb_q.push_back('{"mid_rst_rd", 32'h0});
      e = sb_q.pop_front(); n_checks++;
      if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      e = sb_q.pop_front(); n_checks++;
      if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;

      sb_q.push_back('{"mid_rst_data", 32'h0});
      sb_q.push_back('{"mid_rst_mask", 32'h0});
      sb_q.push_back('{"mid_rst_period", 32'(RESET_PERIOD)});
      sb_q.push_back('{"mid_rst_status", 32'h0});
      for (int a = 0; a < 4; a++) begin
         drive_read(3'(a));
         e = sb_q.pop_front(); n_checks++;
         if (readdata !== e.val) $display("FAIL %s: got %h expected %h", e.name, readdata, e.val); else n_pass++;
      end

      // Mask cleared by reset: pins hold steady while phase keeps toggling.
      drive_write(0, 32'hF);
      for (int k = 1; k <= 10; k++) begin
         sb_q.push_back('{$sformatf("no_blink_pin_k%0d", k), 32'hF});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      end

      drive_write(1, 32'h3);
      drive_write(2, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         ph = ((k - 1) / 2) % 2;
         sb_q.push_back('{$sformatf("resume_pin_k%0d", k), (ph != 0) ? 32'hF : 32'hC});
         @(negedge clk);
         e = sb_q.pop_front(); n_checks++;
         if (32'(out_port) !== e.val) $display("FAIL %s: got %h expected %h", e.name, out_port, e.val); else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      test_reset();
      test_data();
      test_set_clear();
      test_blink();
      test_period_restart();
      test_reset_mid();

      n_checks++;
      if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pio_out_blink.md
# pio_out_blink

Avalon-MM memory-mapped output port driving the board LEDs/indicators from the Nios II system, the output-direction counterpart to the system's key-input PIO. It holds an output data register with atomic bit set/clear access, plus a per-bit blink engine. The blink engine is a programmable prescaler that gates selected bits with a shared phase. All Avalon writes land in one cycle; reads have a fixed latency of one cycle.

## Interface
- WIDTH, 4: number of output bits (1..32)
- DIV_WIDTH, 24: width of period register and prescaler counter (1..32)
- RESET_VALUE, 0: reset value of the data register and of out_port
- RESET_PERIOD, 0: reset value of the period register
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  registered output pins

## Operation
- Write strobe is wr = chipselect & ~write_n. Reads need no strobe: readdata is refreshed every cycle from address.
- Register map (word addresses):
  - 0 data: R/W, WIDTH bits.
  - 1 blink_mask: R/W, WIDTH bits.
  - 2 period: R/W, DIV_WIDTH bits.
  - 3 status: RO; bit0 = phase, other bits 0.
  - 4 outset: WO; data <= data | writedata[WIDTH-1:0].
  - 5 outclear: WO; data <= data & ~writedata[WIDTH-1:0].
  - 6, 7: reserved; writes ignored, read 0.
- Read values are zero-extended to 32 bits. Addresses 4–7 read 0.
- Upper writedata bits beyond WIDTH/DIV_WIDTH are ignored.
- Prescaler behaviour:
  - Counter cnt runs 0..period.
  - When cnt == period: cnt <= 0 and phase <= ~phase.
  - Otherwise cnt <= cnt + 1.
  - Consequence: phase toggles every period+1 cycles; blink frequency = f_clk / (2·(period+1)). period = 0 toggles every cycle.
- A write to period restarts the sequence: cnt <= 0 and phase <= 0 in the same edge. This overrides a coincident wrap.
- Writes to data, blink_mask, outset or outclear do not disturb cnt or phase.
- Output function, registered: out_port[i] <= data[i] & (~blink_mask[i] | phase).
  - Non-blinking bits follow data.
  - Blinking bits show data during phase 1 and 0 during phase 0.
- Reset values:
  - data = RESET_VALUE
  - blink_mask = 0
  - period = RESET_PERIOD
  - cnt = 0, phase = 0
  - out_port = RESET_VALUE
  - readdata = 0
- Reset asserted mid-blink or mid-access returns all state to reset values at that edge. Any write presented in that cycle is discarded.

## Timing
- Write: sampled at rising edge E and visible in the register after E.
- out_port: reflects the new register state after edge E+1, i.e. 2-edge pin latency from the strobe.
- Read: address sampled at edge E; readdata valid after E. A read at E returns the pre-write value of a register written at the same edge E.
- Phase: a change at edge E appears on out_port after E+1.
- Stalls: there is no waitrequest; every access completes in one cycle.
- Back-to-back: outset then outclear on consecutive cycles both apply in order. There are no lost updates.
- cnt is never compared against a stale period. After a period write, cnt = 0, so a shrinking period cannot strand cnt above the new period.

## Test plan
- Reset, no writes: out_port = RESET_VALUE (0), readdata = 0. Reading addr 2 returns RESET_PERIOD; addr 3 returns 0.
- Write data = 0xA at addr 0:
  - out_port = 0xA two edges after the strobe.
  - A read of addr 0 in the next cycle returns 0x0000000A.
  - Write 0xFFFFFFF5 → data = 0x5 (upper bits dropped).
- Atomic set/clear with data = 0x1:
  - outset 0x6 → data = 0x7.
  - outclear 0x3 → data = 0x4.
  - Then back-to-back outset 0x1 / outclear 0x4 → data = 0x1.
  - Reads of addr 4 and 5 return 0.
- Blink with data = 0xF, blink_mask = 0x3, period = 3:
  - Bits 3:2 stay 1.
  - Bits 1:0 are 0 for 4 cycles, then 1 for 4 cycles, repeating.
  - status bit0 toggles every 4 cycles.
  - period = 0 → bits 1:0 toggle every cycle.
- Period write during blink (period = 9, phase = 1, cnt = 5) → write period = 2:
  - Next cycle shows cnt = 0, phase = 0.
  - First toggle occurs 3 cycles later.
  - Repeat the write on the wrap cycle: write wins, phase = 0.
- Synchronous reset asserted mid-blink with a coincident outset write:
  - All registers return to reset values after that edge.
  - Write discarded; out_port = RESET_VALUE one edge later.
  - Blinking resumes only after blink_mask is rewritten.
